// File: rtl/inst_group_unpacker_pkg.sv
// Shared front-end constants and helpers for the instruction-group unpacker
// and the branch-predecode path.
package la32_fe_pkg;

   localparam int GROUP_SLOTS = 4;
   localparam int INST_W      = 32;
   localparam int GRP_PC_W    = 28;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } unpack_state_e;

   // Byte PC of one slot inside a 16-byte aligned group.
   function automatic logic [31:0] slot_pc(input logic [GRP_PC_W-1:0] grp_pc,
                                           input logic [1:0]          slot);
      return {grp_pc, slot, 2'b00};
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/inst_group_unpacker_if.sv
// Buffer-side group handshake and decoder-side issue bundle.
// master drives the payload, slave returns the ready.
interface fe_grp_if;
   import la32_fe_pkg::*;

   logic [GROUP_SLOTS*INST_W-1:0] inst_4W;
   logic [GROUP_SLOTS-1:0]        inst_4W_valid;
   logic [GRP_PC_W-1:0]           inst_4W_pc;
   logic                          pre_valid;
   logic                          out_ready;

   modport master (output inst_4W, inst_4W_valid, inst_4W_pc, pre_valid,
                   input  out_ready);
   modport slave  (input  inst_4W, inst_4W_valid, inst_4W_pc, pre_valid,
                   output out_ready);
endinterface

interface fe_dec_if #(parameter int ISSUE_W = 2);
   logic [32*ISSUE_W-1:0] dec_inst;
   logic [32*ISSUE_W-1:0] dec_pc;
   logic [ISSUE_W-1:0]    dec_lane_valid;
   logic                  out_valid;
   logic                  next_ready;

   modport master (output dec_inst, dec_pc, dec_lane_valid, out_valid,
                   input  next_ready);
   modport slave  (input  dec_inst, dec_pc, dec_lane_valid, out_valid,
                   output next_ready);
endinterface

// File: rtl/inst_group_unpacker_issue_slot_picker.sv
// Picks the first ISSUE_W pending slots of a 4-slot group in program order.
// Lane k gets the k-th lowest set bit of rem. Purely combinational.
module issue_slot_picker
   import la32_fe_pkg::*;
#(
   parameter int ISSUE_W = 2
) (
   input  logic [GROUP_SLOTS-1:0]              rem,
   output logic [ISSUE_W-1:0][GROUP_SLOTS-1:0] lane_onehot,
   output logic [ISSUE_W-1:0][1:0]             lane_idx,
   output logic [GROUP_SLOTS-1:0]              issue_mask
);

   localparam logic [2:0] ISSUE_W3 = 3'(ISSUE_W);

   logic [2:0] below [GROUP_SLOTS];

   // Count of pending slots older than each slot = the lane that slot rides on.
   always_comb begin
      below[0] = 3'd0;
      for (int s = 1; s < GROUP_SLOTS; s++)
         below[s] = below[s-1] + {2'b00, rem[s-1]};
   end

   // Map pending slots onto lanes; slots beyond the issue width wait.
   always_comb begin
      lane_onehot = '0;
      lane_idx    = '0;
      issue_mask  = '0;
      for (int s = 0; s < GROUP_SLOTS; s++) begin
         if (rem[s] && (below[s] < ISSUE_W3))
            issue_mask[s] = 1'b1;
         for (int k = 0; k < ISSUE_W; k++) begin
            if (rem[s] && (below[s] == 3'(k))) begin
               lane_onehot[k][s] = 1'b1;
               lane_idx[k]       = 2'(s);
            end
         end
      end
   end

endmodule

// File: rtl/inst_group_unpacker.sv
// Consumer end of the fetch instruction buffer: takes one 4-slot group per
// handshake and issues its valid slots to decode, ISSUE_W per cycle.
// Optional build macro INST_UNPACK_STAT_EN adds issued-lane and bubble
// counters (stat_issued_cnt, stat_bubble_cnt).
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | rem == 0, nothing held, always ready for a group
// ST_HOLD  | rem != 0, pending slots presented on dec_*
module inst_group_unpacker
   import la32_fe_pkg::*;
#(
   parameter int ISSUE_W = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   fe_grp_if.slave  grp,
   fe_dec_if.master dec
`ifdef INST_UNPACK_STAT_EN
   ,
   output logic [31:0] stat_issued_cnt,
   output logic [31:0] stat_bubble_cnt
`endif
);

   localparam logic [2:0] ISSUE_W3 = 3'(ISSUE_W);

   logic [GROUP_SLOTS-1:0]              rem;
   logic [GROUP_SLOTS-1:0]              rem_nxt;
   logic [GROUP_SLOTS-1:0][INST_W-1:0]  hold_data;
   logic [GRP_PC_W-1:0]                 hold_pc;
   unpack_state_e                       state;

   logic [ISSUE_W-1:0][GROUP_SLOTS-1:0] lane_onehot;
   logic [ISSUE_W-1:0][1:0]             lane_idx;
   logic [GROUP_SLOTS-1:0]              issue_mask;
   logic [2:0]                          rem_cnt;
   logic                                fire;
   logic                                load;
   logic                                ready_c;

   logic [ISSUE_W-1:0][INST_W-1:0]      dec_inst_c;
   logic [ISSUE_W-1:0][31:0]            dec_pc_c;
   logic [ISSUE_W-1:0]                  lane_valid_c;

   issue_slot_picker #(.ISSUE_W(ISSUE_W)) u_picker (
      .rem         (rem),
      .lane_onehot (lane_onehot),
      .lane_idx    (lane_idx),
      .issue_mask  (issue_mask)
   );

   assign rem_cnt = popcount4(rem);
   assign state   = (rem == '0) ? ST_EMPTY : ST_HOLD;

   // Pending-slot mask is the only state; reset drops any held group.
   always_ff @(posedge clk) begin
      if (rst)
         rem <= '0;
      else
         rem <= rem_nxt;
   end

   // Group payload captured on accept; contents only matter while rem != 0.
   always_ff @(posedge clk) begin
      if (load) begin
         hold_data <= grp.inst_4W;
         hold_pc   <= grp.inst_4W_pc;
      end
   end

   // Handshake and next pending mask. A new group overwrites the clear of
   // the last issued slots so groups stream without a bubble; flush wins.
   always_comb begin
      ready_c = 1'b0;
      fire    = 1'b0;
      rem_nxt = rem;
      case (state)
         ST_EMPTY: ready_c = !flush;
         ST_HOLD: begin
            fire    = dec.next_ready;
            ready_c = !flush && dec.next_ready && (rem_cnt <= ISSUE_W3);
         end
         default: ready_c = 1'b0;
      endcase
      load = grp.pre_valid && ready_c;
      if (fire)
         rem_nxt = rem & ~issue_mask;
      if (load)
         rem_nxt = grp.inst_4W_valid;
      if (flush)
         rem_nxt = '0;
   end

   // Steer held slots onto decode lanes, oldest on lane 0.
   always_comb begin
      dec_inst_c   = '0;
      dec_pc_c     = '0;
      lane_valid_c = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         dec_inst_c[k]   = hold_data[lane_idx[k]];
         dec_pc_c[k]     = slot_pc(hold_pc, lane_idx[k]);
         lane_valid_c[k] = |lane_onehot[k];
      end
   end

   assign dec.dec_inst       = dec_inst_c;
   assign dec.dec_pc         = dec_pc_c;
   assign dec.dec_lane_valid = lane_valid_c;
   assign dec.out_valid      = (state == ST_HOLD);
   assign grp.out_ready      = ready_c;

`ifdef INST_UNPACK_STAT_EN
   // Issued-lane and idle-cycle counters; flush leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued_cnt <= '0;
         stat_bubble_cnt <= '0;
      end else begin
         if (fire)
            stat_issued_cnt <= stat_issued_cnt + {29'd0, popcount4(issue_mask)};
         if (state == ST_EMPTY)
            stat_bubble_cnt <= stat_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
